// File: rtl/telemetry_deserialize.sv
// telemetry_deserialize
//   Receive end of the telemetry serial link. Oversamples a single-ended line
//   (idle high, start 0, PACKET_WIDTH data bits LSB first, optional even parity,
//   stop 1) and presents each good frame as a parallel word with a 1-cycle strobe.
//
// Optional feature macro: TELEM_RX_PARITY_EN (adds an even-parity bit after data).
//
// Ports:
//   clk          in   sample clock, OVERSAMPLE x bit rate
//   rst_n        in   asynchronous active-low reset
//   serial_in    in   asynchronous serial line, idles high
//   packet       out  last recovered payload, bit 0 = first bit received
//   packet_valid out  one-cycle strobe, packet is new this cycle
//   frame_err    out  one-cycle strobe on bad stop (or bad parity) bit
//   busy         out  high whenever the receiver is not idle
module telemetry_deserialize #(
    parameter int unsigned PACKET_WIDTH = 88,
    parameter int unsigned OVERSAMPLE   = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    serial_in,
    output logic [PACKET_WIDTH-1:0] packet,
    output logic                    packet_valid,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int unsigned PhW  = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = $clog2(PACKET_WIDTH + 1);
    localparam int unsigned FlW  = $clog2(SYNC_STAGES + 2);

    localparam logic [PhW-1:0]  PhMid   = PhW'(OVERSAMPLE / 2 - 1);
    localparam logic [PhW-1:0]  PhLast  = PhW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(PACKET_WIDTH - 1);
    localparam logic [FlW-1:0]  FlDone  = FlW'(SYNC_STAGES + 1);

`ifdef TELEM_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t                  r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_s_prev;
    logic [FlW-1:0]          r_flush;
    logic [PhW-1:0]          r_phase, w_phase_nxt;
    logic [IdxW-1:0]         r_idx, w_idx_nxt;
    logic [PACKET_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [PACKET_WIDTH-1:0] r_packet, w_packet_nxt;
    logic                    r_valid, w_valid_nxt;
    logic                    r_err, w_err_nxt;
`ifdef TELEM_RX_PARITY_EN
    logic                    r_par, w_par_nxt;
    logic                    r_par_err, w_par_err_nxt;
`endif

    logic w_s;
    logic w_fall;

    assign w_s = r_sync[SYNC_STAGES-1];
    // Edges are ignored until the synchronizer and r_s_prev hold real line
    // samples, so a line already low at reset release is not taken as a start.
    assign w_fall = (r_flush == FlDone) && r_s_prev && !w_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '1;
            r_s_prev <= 1'b1;
            r_flush  <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], serial_in};
            r_s_prev <= w_s;
            if (r_flush != FlDone) begin
                r_flush <= r_flush + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase + 1'b1;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_packet_nxt = r_packet;
        w_valid_nxt  = 1'b0;
        w_err_nxt    = 1'b0;
`ifdef TELEM_RX_PARITY_EN
        w_par_nxt     = r_par;
        w_par_err_nxt = r_par_err;
`endif
        unique case (r_state)
            IDLE: begin
                w_phase_nxt = '0;
                w_idx_nxt   = '0;
`ifdef TELEM_RX_PARITY_EN
                w_par_nxt     = 1'b0;
                w_par_err_nxt = 1'b0;
`endif
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_phase == PhMid) begin
                    w_phase_nxt = '0;
                    w_state_nxt = w_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_phase == PhLast) begin
                    w_phase_nxt        = '0;
                    w_shift_nxt[r_idx] = w_s;
`ifdef TELEM_RX_PARITY_EN
                    w_par_nxt = r_par ^ w_s;
`endif
                    if (r_idx == IdxLast) begin
`ifdef TELEM_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
`ifdef TELEM_RX_PARITY_EN
            PARITY: begin
                if (r_phase == PhLast) begin
                    w_phase_nxt   = '0;
                    w_par_err_nxt = r_par ^ w_s;
                    w_state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (r_phase == PhLast) begin
                    w_phase_nxt = '0;
                    if (w_s) begin
                        w_state_nxt = IDLE;
`ifdef TELEM_RX_PARITY_EN
                        if (r_par_err) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_packet_nxt = r_shift;
                            w_valid_nxt  = 1'b1;
                        end
`else
                        w_packet_nxt = r_shift;
                        w_valid_nxt  = 1'b1;
`endif
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Phase counter doubles as the run length of consecutive 1s.
                if (!w_s) begin
                    w_phase_nxt = '0;
                end else if (r_phase == PhLast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_packet <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
`ifdef TELEM_RX_PARITY_EN
            r_par     <= 1'b0;
            r_par_err <= 1'b0;
`endif
        end else begin
            r_phase  <= w_phase_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_packet <= w_packet_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
`ifdef TELEM_RX_PARITY_EN
            r_par     <= w_par_nxt;
            r_par_err <= w_par_err_nxt;
`endif
        end
    end

    assign packet       = r_packet;
    assign packet_valid = r_valid;
    assign frame_err    = r_err;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_telemetry_deserialize.sv
// Bench for telemetry_deserialize: frames are generated from the line format,
// expected outcomes are queued by the driver and checked by a separate monitor.
module tb_telemetry_deserialize;

    localparam int unsigned W   = 88;
    localparam int unsigned OS  = 4;
    localparam int unsigned SYN = 2;
`ifdef TELEM_RX_PARITY_EN
    localparam int unsigned FRAME_CLKS = (W + 3) * OS;
`else
    localparam int unsigned FRAME_CLKS = (W + 2) * OS;
`endif

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         serial_in;
    logic [W-1:0] packet;
    logic         packet_valid;
    logic         frame_err;
    logic         busy;

    exp_t         q[$];
    int           valid_cyc[$];
    logic [W-1:0] last_good;
    int           compared;
    int           mismatched;
    int           cyc;

    telemetry_deserialize #(
        .PACKET_WIDTH(W),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SYN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .packet      (packet),
        .packet_valid(packet_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (packet_valid && frame_err) begin
                compared++;
                mismatched++;
                $display("FAIL both_strobes: actual=11 required=not both");
            end
            if (packet_valid || frame_err) begin
                if (packet_valid) valid_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_strobe: actual valid=%0b err=%0b packet=%0h required=none",
                             packet_valid, frame_err, packet);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_kind_err", {127'b0, frame_err}, {127'b0, e.err});
                    chk("strobe_packet", {40'b0, packet}, {40'b0, e.data});
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        serial_in = 1'b1;
        repeat (n * OS) @(negedge clk);
    endtask

    // Model: a frame is reported good only with stop=1 and (optionally) even parity.
    task automatic send_frame(input logic [W-1:0] d, input logic good_stop, input logic bad_par);
        logic par;
        logic ok;
        exp_t e;
`ifdef TELEM_RX_PARITY_EN
        par = (^d) ^ bad_par;
        ok  = good_stop && !bad_par;
`else
        par = 1'b0;
        ok  = good_stop;
`endif
        if (ok) begin
            e.err     = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.err  = 1'b1;
            e.data = last_good;
        end
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < int'(W); i++) drive_bit(d[i]);
`ifdef TELEM_RX_PARITY_EN
        drive_bit(par);
`endif
        if (good_stop) begin
            drive_bit(1'b1);
        end else begin
            drive_bit(1'b0);
            serial_in = 1'b0;
            repeat (10) @(negedge clk);
            idle_bits(3);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 4 * int'(FRAME_CLKS)) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(q.size()), 128'd0);
    endtask

    function automatic logic [W-1:0] rand_word();
        return W'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        logic [W-1:0] d;
        int           base;
        int           n;
        logic         saw_busy;
        compared   = 0;
        mismatched = 0;
        last_good  = '0;
        serial_in  = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_packet", {40'b0, packet}, 128'd0);
        chk("reset_valid", {127'b0, packet_valid}, 128'd0);
        chk("reset_err", {127'b0, frame_err}, 128'd0);
        chk("reset_busy", {127'b0, busy}, 128'd0);
        rst_n = 1'b1;
        idle_bits(3);

        // Single known frame.
        send_frame(88'h0123_4567_89AB_CDEF_FEDC_BA, 1'b1, 1'b0);
        idle_bits(2);
        wait_drain("single_drain");

        // Back-to-back frames with no idle gap.
        base = valid_cyc.size();
        send_frame(88'h1, 1'b1, 1'b0);
        send_frame(88'h2, 1'b1, 1'b0);
        idle_bits(2);
        wait_drain("b2b_drain");
        chk("b2b_count", 128'(valid_cyc.size() - base), 128'd2);
        if (valid_cyc.size() >= base + 2)
            chk("b2b_spacing", 128'(valid_cyc[base+1] - valid_cyc[base]), 128'(FRAME_CLKS));

        // One-clock glitch on an idle line.
        serial_in = 1'b0;
        @(negedge clk);
        serial_in = 1'b1;
        saw_busy  = 1'b0;
        for (int i = 0; i < int'(SYN) + 5; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        chk("glitch_seen", {127'b0, saw_busy}, 128'd1);
        chk("glitch_busy_clear", {127'b0, busy}, 128'd0);
        idle_bits(2);

        // Bad stop bit, then a good frame.
        send_frame(rand_word(), 1'b0, 1'b0);
        wait_drain("badstop_drain");
        send_frame(88'h5A, 1'b1, 1'b0);
        idle_bits(2);
        wait_drain("after_badstop_drain");

        // Reset mid-frame with the line left low across release.
        d = rand_word();
        d[40] = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 40; i++) drive_bit(d[i]);
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_busy", {127'b0, busy}, 128'd0);
        chk("midreset_packet", {40'b0, packet}, 128'd0);
        last_good = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("low_after_reset_busy", {127'b0, busy}, 128'd0);
        idle_bits(3);
        send_frame(88'hA5, 1'b1, 1'b0);
        idle_bits(2);
        wait_drain("midreset_drain");

`ifdef TELEM_RX_PARITY_EN
        send_frame(88'h3, 1'b1, 1'b0);
        send_frame(88'h3, 1'b1, 1'b1);
        idle_bits(2);
        wait_drain("parity_drain");
`endif

        // Random frames with random gaps and occasional corruption.
        for (int k = 0; k < 24; k++) begin
            logic gs;
            logic bp;
            gs = ($urandom_range(0, 5) != 0);
            bp = ($urandom_range(0, 5) == 0);
            send_frame(rand_word(), gs, bp);
            n = $urandom_range(0, 2);
            if (n != 0) idle_bits(n);
        end
        idle_bits(3);
        wait_drain("random_drain");

        repeat (2 * FRAME_CLKS) @(negedge clk);
        chk("final_queue_empty", 128'(q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/telemetry_deserialize.md
Name: telemetry_deserialize

Overview:
- Receive end of the telemetry serial link. Recovers fixed-width packets from the single-ended serial bit stream produced by telemetry_serialize.
- Samples the line in one clock domain, at OVERSAMPLE times the bit rate.
- Presents each recovered packet as a parallel word with a one-cycle valid strobe.
- Sits between the board serial input and downstream packet logic (FIFO / FT600 stream path) on the protonpack receiver.

Parameters:
- PACKET_WIDTH, 88: payload bits per frame.
- OVERSAMPLE, 4: clock cycles per serial bit; must be >= 4 and even.
- SYNC_STAGES, 2: flops in the input synchronizer; must be >= 2.

Ports:
- clk  input  1  sample clock, OVERSAMPLE x bit rate.
- rst_n  input  1  asynchronous active-low reset.
- serial_in  input  1  asynchronous serial line; idles high.
- packet  output  PACKET_WIDTH  last recovered payload; bit 0 is the first bit received.
- packet_valid  output  1  one-cycle strobe; packet is new this cycle.
- frame_err  output  1  one-cycle strobe on bad stop bit (or bad parity when the option is enabled).
- busy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: packet = 0, packet_valid = 0, frame_err = 0, busy = 0, state = IDLE, synchronizer flops = 1.
- Frame on the line:
  - idle 1;
  - start bit 0;
  - PACKET_WIDTH data bits, LSB first;
  - [parity bit, option only];
  - stop bit 1.
  - Every bit is OVERSAMPLE clocks long.
- serial_in passes through SYNC_STAGES flops. All decisions use the synchronized value s.
- IDLE:
  - falling edge on s (previous 1, current 0) -> START; phase counter cleared.
- START:
  - at phase OVERSAMPLE/2-1 (mid-bit), resample s;
  - s = 0 -> DATA, bit index = 0, phase counter restarts;
  - s = 1 -> glitch: IDLE, no strobe.
- DATA:
  - sample s each time the phase counter reaches OVERSAMPLE-1; counter wraps to 0 (mid-bit alignment kept from START);
  - shift into the shift register at position bit index; increment bit index;
  - after bit PACKET_WIDTH-1 -> STOP (or PARITY when the option is enabled).
- STOP, at mid-bit sample:
  - s = 1: packet <= shift register; packet_valid = 1 on the next cycle; -> IDLE;
  - s = 0: frame_err = 1 on the next cycle; packet unchanged; -> WAIT_IDLE.
- WAIT_IDLE:
  - stay until s has been 1 for OVERSAMPLE consecutive clocks, then -> IDLE;
  - prevents false start detection inside a corrupt frame.
- Back-to-back frames:
  - a start bit that begins immediately after the stop bit's mid-sample must be caught;
  - the IDLE falling-edge detector uses the previous s value, which stays valid across the STOP -> IDLE transition.
- Latency: packet_valid rises SYNC_STAGES + 1 clocks after the stop-bit mid-sample point reaches the pin.
- Counters:
  - phase counter: $clog2(OVERSAMPLE) bits;
  - bit index: $clog2(PACKET_WIDTH+1) bits;
  - neither may overflow for the default parameters.
- packet holds its value until the next good frame.
- packet_valid and frame_err are never high in the same cycle.
- busy is high in every state except IDLE, including WAIT_IDLE.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded.
  - After release, a line already low is not a start; IDLE requires a 1 -> 0 edge.

Optional Feature:
- Macro TELEM_RX_PARITY_EN.
- Defined:
  - a PARITY state follows DATA and samples one extra bit;
  - expected parity is even: XOR of the data bits and the parity bit is 0;
  - on mismatch, the STOP sample still occurs;
  - with a good stop bit, no packet_valid; frame_err pulses instead; -> IDLE;
  - with a bad stop bit, the behaviour is as without the option.
- Not defined: no PARITY state; the frame is start + data + stop, with no parity logic synthesized.
- The serializer must be built with the matching setting.

Test Plan:
- Single frame: after reset, drive one frame with payload 88'h0123_4567_89AB_CDEF_FEDC_BA, OVERSAMPLE = 4 -> exactly one packet_valid pulse, packet equal to the payload, frame_err stays 0.
- Back-to-back frames: send payload 88'h1, then 88'h2 with no idle gap -> two packet_valid pulses, PACKET_WIDTH+2 bits x 4 = 360 clocks apart; values 1 then 2.
- Glitch and reset: low pulse of 1 clock on an idle line -> no strobe, busy returns to 0 within 3 clocks. Also drive rst_n low at data bit 40 of a frame, then send a full frame with payload 88'hA5 -> only the second frame is reported, as 88'hA5.
- Bad stop bit: stop bit forced to 0, line held low 10 clocks, then high -> one frame_err pulse, no packet_valid, packet keeps its prior value. A following good frame with payload 88'h5A is received correctly.
- Parity (TELEM_RX_PARITY_EN): payload 88'h3 with parity bit 0 -> packet_valid. Same payload with parity bit 1 -> frame_err, no packet_valid.
- Loopback with telemetry_test_counter -> telemetry_serialize at clk4x = clk: 100 consecutive packets match the transmitted packet sequence with zero frame_err pulses.
